bcd_down_counter: RTL

- Multi-digit synchronous BCD down counter (countdown timer), the decrementing counterpart of the team's mod-10 up counter.
- Counts a loaded decimal value down to zero one digit-borrow chain at a time; flags terminal count and optionally auto-reloads.
- Used as a programmable delay/timeout source feeding display and control logic.

---
 rtl/bcd_down_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with load, terminal-count pulse and optional
// periodic auto-reload. All outputs are registered.
module bcd_down_counter #(
    parameter int unsigned DIGITS         = 2,
    parameter bit          RELOAD_DEFAULT = 1'b0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  running,
    output logic                  done
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] reload_q;
    logic         mode_q;

    logic [W-1:0] sat_val;
    logic [W-1:0] dec_val;
    logic         borrow;

    logic [W-1:0] count_n;
    logic [W-1:0] reload_n;
    logic         mode_n;
    logic         tc_n;
    logic         running_n;
    logic         done_n;

    // Clamp each preset digit to 9 so the counter only ever holds valid BCD.
    always_comb begin
        sat_val = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                sat_val[4*i +: 4] = 4'd9;
            end else begin
                sat_val[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Single-cycle decimal borrow ripple across all digits.
    always_comb begin
        dec_val = count;
        borrow  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_n   = count;
        reload_n  = reload_q;
        mode_n    = mode_q;
        tc_n      = 1'b0;
        running_n = running;
        done_n    = done;

        if (load) begin
            count_n   = sat_val;
            reload_n  = sat_val;
            mode_n    = auto_reload;
            done_n    = 1'b0;
            running_n = (sat_val != '0);
        end else if (en && running) begin
            if (count == W'(1)) begin
                count_n = '0;
                tc_n    = 1'b1;
                if (!mode_q) begin
                    running_n = 1'b0;
                    done_n    = 1'b1;
                end
            end else if (count == '0) begin
                // Only reachable in periodic mode: restart without a second tc.
                count_n = reload_q;
            end else begin
                count_n = dec_val;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count    <= '0;
            reload_q <= '0;
            mode_q   <= RELOAD_DEFAULT;
            tc       <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            count    <= count_n;
            reload_q <= reload_n;
            mode_q   <= mode_n;
            tc       <= tc_n;
            running  <= running_n;
            done     <= done_n;
        end
    end

endmodule
